// File: rtl/lab2_pkg.sv
// Shared types and sizing helpers for the lab2 truth-table sweep sequencer.
package lab2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int SETTLE_CYC_DEF = 1;

    // One truth-table bit per possible input vector.
    function automatic int tbl_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/lab2_sweep_cnt.sv
// Vector counter driving the evaluator inputs; terminal count flags the last vector.
module lab2_sweep_cnt #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [N_IN-1:0] vec_o,
    output logic            tc_o
);

    logic [N_IN-1:0] vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (clr_i) begin
            vec_q <= '0;
        end else if (inc_i) begin
            vec_q <= vec_q + 1'b1;
        end
    end

    assign vec_o = vec_q;
    assign tc_o  = &vec_q;

endmodule

// File: rtl/lab2_sweep_ctrl.sv
// Sweeps every input vector through an external combinational evaluator,
// captures its output into a truth table and compares it with a latched signature.
module lab2_sweep_ctrl
    import lab2_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [tbl_width(N_IN)-1:0] expected,
    output logic [N_IN-1:0]            vec,
    input  logic                       dut_out,
    output logic [tbl_width(N_IN)-1:0] table_q,
    output logic                       busy,
    output logic                       done,
    output logic                       match
);

    localparam int TW    = tbl_width(N_IN);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_d;
    logic            busy_q;
    logic            done_q;
    logic            match_q;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            vec_tc;

    assign cnt_clr = (state_q == IDLE) && start && !abort;
    assign cnt_inc = (state_q == SAMPLE) && !abort && !vec_tc;

    lab2_sweep_cnt #(
        .N_IN (N_IN)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .vec_o (vec),
        .tc_o  (vec_tc)
    );

    // Table as it would look after capturing the current vector; used for the match on entry to DONE.
    always_comb begin
        table_d      = table_q;
        table_d[vec] = dut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= SETTLE;
                        table_q <= '0;
                        exp_q   <= expected;
                        match_q <= 1'b0;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        table_q <= table_d;
                        if (vec_tc) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= (table_d == exp_q);
                        end else begin
                            state_q <= SETTLE;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign match = match_q;

endmodule

// File: tb/tb_lab2_sweep_ctrl.sv
// Randomized self-checking bench for lab2_sweep_ctrl: two instances (4-input/settle 1, 3-input/settle 3)
// checked against a cycle-level reference derived from the sweep timing rules.
module tb_lab2_sweep_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        startA = 1'b0;
    logic        abortA = 1'b0;
    logic [15:0] expA   = '0;
    logic [3:0]  vecA;
    logic        dutOutA;
    logic [15:0] tableA;
    logic        busyA, doneA, matchA;
    logic [15:0] evalTblA = '0;

    logic        startB = 1'b0;
    logic        abortB = 1'b0;
    logic [7:0]  expB   = '0;
    logic [2:0]  vecB;
    logic        dutOutB;
    logic [7:0]  tableB;
    logic        busyB, doneB, matchB;

    assign dutOutA = evalTblA[vecA];
    assign dutOutB = vecB[2] | (vecB[1] & vecB[0]);

    lab2_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(1)) u_dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startA),
        .abort    (abortA),
        .expected (expA),
        .vec      (vecA),
        .dut_out  (dutOutA),
        .table_q  (tableA),
        .busy     (busyA),
        .done     (doneA),
        .match    (matchA)
    );

    lab2_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(3)) u_dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startB),
        .abort    (abortB),
        .expected (expB),
        .vec      (vecB),
        .dut_out  (dutOutB),
        .table_q  (tableB),
        .busy     (busyB),
        .done     (doneB),
        .match    (matchB)
    );

    int assertCount = 0;
    int failCount   = 0;
    int selIdx      = 0;

    logic [31:0] obsVec;
    logic [31:0] obsTable;
    logic        obsBusy, obsDone, obsMatch;

    always_comb begin
        if (selIdx == 0) begin
            obsVec   = {28'd0, vecA};
            obsTable = {16'd0, tableA};
            obsBusy  = busyA;
            obsDone  = doneA;
            obsMatch = matchA;
        end else begin
            obsVec   = {29'd0, vecB};
            obsTable = {24'd0, tableB};
            obsBusy  = busyB;
            obsDone  = doneB;
            obsMatch = matchB;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        assertCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic startV, input logic abortV);
        if (sel == 0) begin
            startA = startV;
            abortA = abortV;
        end else begin
            startB = startV;
            abortB = abortV;
        end
    endtask

    task automatic driveExpected(input int sel, input logic [15:0] v);
        if (sel == 0) expA = v;
        else          expB = v[7:0];
    endtask

    // Reference truth table of x | (y & z) over the 3-bit vector {x,y,z}.
    function automatic logic [15:0] modelOut2();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if ((i / 4) == 1 || (i % 4) == 3) m[i] = 1'b1;
        end
        return m;
    endfunction

    // One full sweep: vector k must be presented for cycles k*(S+1)+1 .. (k+1)*(S+1),
    // done exactly at cycle 2**n*(S+1)+1, busy for every cycle before it.
    task automatic runSweep(input int sel, input int nIn, input int settle,
                            input logic [15:0] modelTbl, input logic [15:0] expT,
                            input bit holdStart, input bit scrambleExp, input string tag);
        int nVec, doneAt, vecErr, busyErr, doneErr, wantVec;
        nVec    = 1 << nIn;
        doneAt  = nVec * (settle + 1) + 1;
        vecErr  = 0;
        busyErr = 0;
        doneErr = 0;
        selIdx  = sel;
        @(negedge clk);
        driveExpected(sel, expT);
        applyStimulus(sel, 1'b1, 1'b0);
        for (int c = 1; c <= doneAt + 3; c++) begin
            @(negedge clk);
            if (c == 1 && !holdStart) applyStimulus(sel, 1'b0, 1'b0);
            if (scrambleExp) driveExpected(sel, 16'($urandom));
            wantVec = (c < doneAt) ? (c - 1) / (settle + 1) : nVec - 1;
            if (obsVec != 32'(wantVec)) vecErr++;
            if (obsBusy != (c < doneAt)) busyErr++;
            if (obsDone != (c == doneAt)) doneErr++;
            if (c == doneAt) begin
                checkOutput({tag, ".table"}, obsTable, {16'd0, modelTbl});
                checkOutput({tag, ".match"}, {31'd0, obsMatch}, {31'd0, modelTbl == expT});
                if (holdStart) applyStimulus(sel, 1'b0, 1'b0);
            end
        end
        checkOutput({tag, ".vecSeq"}, 32'(vecErr), 0);
        checkOutput({tag, ".busySeq"}, 32'(busyErr), 0);
        checkOutput({tag, ".donePulse"}, 32'(doneErr), 0);
        checkOutput({tag, ".matchHold"}, {31'd0, obsMatch}, {31'd0, modelTbl == expT});
    endtask

    initial begin
        logic [15:0] ev;
        logic [15:0] ex;
        int          busySeen;
        int          doneSeen;

        #1;
        checkOutput("rst.vecA", {28'd0, vecA}, 0);
        checkOutput("rst.tableA", {16'd0, tableA}, 0);
        checkOutput("rst.flagsA", {29'd0, busyA, doneA, matchA}, 0);
        checkOutput("rst.vecB", {29'd0, vecB}, 0);
        checkOutput("rst.tableB", {24'd0, tableB}, 0);
        checkOutput("rst.flagsB", {29'd0, busyB, doneB, matchB}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        evalTblA = 16'hC088;
        runSweep(0, 4, 1, 16'hC088, 16'hC088, 1'b0, 1'b0, "net4");

        runSweep(1, 3, 3, modelOut2(), 16'h00F8, 1'b0, 1'b0, "out2pass");
        runSweep(1, 3, 3, modelOut2(), 16'h00F0, 1'b0, 1'b0, "out2fail");

        for (int r = 0; r < 4; r++) begin
            ev = 16'($urandom);
            ex = (r % 2 == 0) ? ev : (ev ^ (16'h1 << $urandom_range(15, 0)));
            evalTblA = ev;
            runSweep(0, 4, 1, ev, ex, 1'b0, 1'b1, "rand");
        end

        evalTblA = 16'hFFFF;
        runSweep(0, 4, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "ones");

        // Abort in the SAMPLE cycle of vector 5 (cycle 12).
        selIdx = 0;
        @(negedge clk);
        driveExpected(0, 16'hFFFF);
        applyStimulus(0, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(0, 1'b0, 1'b0);
        end
        checkOutput("abort.preVec", {28'd0, vecA}, 5);
        applyStimulus(0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("abort.busy", {31'd0, busyA}, 0);
        checkOutput("abort.table", {16'd0, tableA}, 32'h001F);
        checkOutput("abort.match", {31'd0, matchA}, 0);
        checkOutput("abort.vec", {28'd0, vecA}, 5);
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (doneA || busyA) doneSeen++;
        end
        checkOutput("abort.quiet", 32'(doneSeen), 0);
        runSweep(0, 4, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "afterAbort");

        evalTblA = 16'h5A3C;
        runSweep(0, 4, 1, 16'h5A3C, 16'h5A3C, 1'b1, 1'b0, "holdStart");

        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1);
        busySeen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busyA) busySeen++;
        end
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("startAbortIdle", 32'(busySeen), 0);

        // Asynchronous reset while vector 9 is settling (cycle 19).
        evalTblA = 16'hFFFF;
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(0, 1'b0, 1'b0);
        end
        checkOutput("rstMid.preVec", {28'd0, vecA}, 9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstMid.vec", {28'd0, vecA}, 0);
        checkOutput("rstMid.table", {16'd0, tableA}, 0);
        checkOutput("rstMid.flags", {29'd0, busyA, doneA, matchA}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (doneA || busyA) doneSeen++;
        end
        checkOutput("rstMid.quiet", 32'(doneSeen), 0);
        evalTblA = 16'h0F0F;
        runSweep(0, 4, 1, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, "afterRst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lab2_sweep_ctrl.md
Name: lab2_sweep_ctrl

Overview:
Sequencer that exhaustively drives every input vector into one external combinational lab2 gate network and captures its output into a truth-table register.
- After the sweep it compares the captured table against an expected signature and reports pass/fail.
- It sits between a test/configuration host (start/abort/expected) and a single shared combinational evaluator (vec out, dut_out in).

Parameters:
- N_IN, 4, number of evaluator inputs; sweep covers 2**N_IN vectors (legal 1..6).
- SETTLE_CYC, 1, cycles vec is held stable before sampling dut_out (legal >= 1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a sweep; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- expected  in  2**N_IN  golden truth table; latched on accepted start.
- vec  out  N_IN  input vector driven to the evaluator.
- dut_out  in  1  evaluator output for the current vec.
- table_q  out  2**N_IN  captured truth table; bit i = dut_out for vec==i.
- busy  out  1  high in SETTLE/SAMPLE.
- done  out  1  one-cycle pulse at sweep completion.
- match  out  1  table_q == expected latch; valid from done until next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec=0, table_q=0, expected latch=0, busy=0, done=0, match=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 -> SETTLE; vec<=0, table_q<=0, latch expected, match<=0, cnt<=SETTLE_CYC-1.
  - start and abort together -> stay IDLE (abort wins).
- SETTLE: cnt==0 -> SAMPLE, else cnt<=cnt-1. vec held constant.
- SAMPLE (one cycle): table_q[vec]<=dut_out.
  - vec==2**N_IN-1 -> DONE.
  - Otherwise vec<=vec+1, cnt<=SETTLE_CYC-1, -> SETTLE.
  - vec never wraps during a sweep.
- DONE (one cycle): done=1; match<=(table_q==expected latch) registered on entry, so it is valid in the DONE cycle; -> IDLE.
- Timing: cycles per vector = SETTLE_CYC+1. The first SETTLE cycle follows the start edge. done is high exactly 2**N_IN*(SETTLE_CYC+1)+1 cycles after start is sampled (defaults: 33).
- abort=1 in SETTLE or SAMPLE -> IDLE next edge:
  - no done pulse, no capture in that SAMPLE;
  - table_q keeps partial contents; match stays 0; vec holds its value.
- abort in DONE is ignored (done still pulses).
- start while busy or in DONE: ignored, not queued.
- expected changing mid-sweep has no effect (latched copy used).
- vec changes only on a SAMPLE->SETTLE edge or on the IDLE start edge. The evaluator therefore sees each vector stable for >= SETTLE_CYC+1 cycles.
- busy = (state==SETTLE || state==SAMPLE), decoded from registered state, glitch-free.
- Reset mid-sweep: immediate return to reset values; no done.

Decomposition:
- Package lab2_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SETTLE, SAMPLE, DONE};
  - localparam function for table width (2**N_IN);
  - default SETTLE_CYC constant.
- One sub-module, lab2_sweep_cnt: vector counter with load-zero, increment, and terminal-count flag (vec==max). Clock/reset shared; async active-low reset.
- Settle counter stays inline in the FSM.

Test Plan:
- Defaults; evaluator = lab2 4-input network wired in1=vec[3], in2=vec[2], in3=vec[1], in4=vec[0]; expected=16'hC088; pulse start -> done at cycle 33, table_q=16'hC088, match=1, busy high for cycles 1..32.
- N_IN=3; evaluator out2 = x|(y&z) with x=vec[2], y=vec[1], z=vec[0]; expected=8'hF8 -> table_q=8'hF8, match=1. Rerun with expected=8'hF0 -> match=0, table_q=8'hF8.
- SETTLE_CYC=3, evaluator dut_out=vec[0], expected=16'hAAAA -> each vec value held 4 cycles; done at cycle 65; match=1.
- abort asserted during SAMPLE of vec=5 (evaluator dut_out=1) -> IDLE next cycle, no done, table_q=16'h001F, match=0; a new start then completes normally.
- start held high through a full sweep -> exactly one sweep per accepted start in IDLE. start+abort same cycle in IDLE -> no sweep. start during busy -> ignored.
- rst_n pulled low asynchronously mid-cycle at vec=9 -> all outputs 0 immediately, no done; release and start -> clean sweep from vec=0.
